// File: rtl/astro_pkg.sv
// Shared types and constants for the astrometry window scan: scan FSM states,
// the 32.32 signed log2 NCC score type and the search geometry.
package astro_pkg;

  localparam int SEARCH_DIM = 80;
  localparam int WIN_DIM    = 16;
  localparam int STRIDE     = 4;
  localparam int POS        = (SEARCH_DIM - WIN_DIM) / STRIDE + 1;

  typedef logic signed [63:0] ncc_log2_t;

  localparam ncc_log2_t NCC_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_WIN,
    WAIT_SCORE,
    NEXT,
    DONE
  } scan_state_t;

endpackage

// File: rtl/scan_pos_counter.sv
// Row/column counters over the window origin grid, with wrap, last-position
// flag and the row-major window index.
module scan_pos_counter #(
  parameter int NUM_POS = astro_pkg::POS,
  parameter int CNT_W   = $clog2(NUM_POS),
  parameter int IDX_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             last,
  output logic [IDX_W-1:0] index
);

  logic col_wrap;
  logic row_wrap;

  assign col_wrap = (col == CNT_W'(NUM_POS - 1));
  assign row_wrap = (row == CNT_W'(NUM_POS - 1));
  assign last     = col_wrap && row_wrap;
  assign index    = IDX_W'(row) * IDX_W'(NUM_POS) + IDX_W'(col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_wrap) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/window_scan_scheduler.sv
// Walks 16x16 window origins over the search area, collects NCC scores and keeps the best.
// Optional per-wait watchdog with sticky err is enabled by defining SCAN_TIMEOUT_EN.
module window_scan_scheduler #(
  parameter int SEARCH_DIM  = 80,
  parameter int WIN_DIM     = 16,
  parameter int STRIDE      = 4,
  parameter int IDX_W       = 9,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             win_req,
  output logic [6:0]       win_row,
  output logic [6:0]       win_col,
  input  logic             win_ready,
  input  logic             score_valid,
  input  logic [63:0]      score,
  output logic             busy,
  output logic             set_done,
  output logic [63:0]      best_score,
  output logic [IDX_W-1:0] best_index,
  output logic             err
);
  import astro_pkg::*;

  localparam int NPOS  = (SEARCH_DIM - WIN_DIM) / STRIDE + 1;
  localparam int CNT_W = $clog2(NPOS);

  scan_state_t      state, state_next;
  logic [CNT_W-1:0] row_cnt, col_cnt;
  logic [IDX_W-1:0] pos_index;
  logic             last_pos;
  logic             accept_start;
  logic             score_take;
  logic             timed_out;
  ncc_log2_t        best_q;

  assign accept_start = (state == IDLE) && start && !abort;
  assign score_take   = (state == WAIT_SCORE) && score_valid && !abort;

  scan_pos_counter #(
    .NUM_POS (NPOS),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept_start),
    .advance ((state == NEXT) && !abort && !last_pos),
    .row     (row_cnt),
    .col     (col_cnt),
    .last    (last_pos),
    .index   (pos_index)
  );

  // Counters only move in NEXT, so the origin is stable from ISSUE until the next window.
  assign win_row = 7'(row_cnt * STRIDE);
  assign win_col = 7'(col_cnt * STRIDE);

`ifdef SCAN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);

  logic [TO_W-1:0] wait_cnt;
  logic            in_wait;
  logic            err_q;

  assign in_wait   = (state == WAIT_WIN) || (state == WAIT_SCORE);
  assign timed_out = in_wait && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (in_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept_start) begin
      err_q <= 1'b0;
    end else if (in_wait && (state_next == DONE)) begin
      err_q <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort outranks every other event; a handshake arriving on the watchdog's last cycle still wins.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:       if (start) state_next = ISSUE;
        ISSUE:      state_next = WAIT_WIN;
        WAIT_WIN:   if (win_ready) state_next = WAIT_SCORE;
                    else if (timed_out) state_next = DONE;
        WAIT_SCORE: if (score_valid) state_next = NEXT;
                    else if (timed_out) state_next = DONE;
        NEXT:       state_next = last_pos ? DONE : ISSUE;
        DONE:       state_next = IDLE;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    win_req  = 1'b0;
    busy     = 1'b0;
    set_done = 1'b0;
    win_req  = (state == ISSUE);
    busy     = (state != IDLE);
    set_done = (state == DONE);
  end

  // Strict greater-than keeps the earlier index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q     <= '0;
      best_index <= '0;
    end else if (accept_start) begin
      best_q     <= NCC_MIN;
      best_index <= '0;
    end else if (score_take && ($signed(score) > best_q)) begin
      best_q     <= $signed(score);
      best_index <= pos_index;
    end
  end

  assign best_score = best_q;

endmodule
